// File: rtl/bulk_out_ctrl_if.sv
// Byte-wide AXI-Stream link used for the decoder->controller and controller->FIFO payload paths.
interface bulk_out_ctrl_if;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic [7:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/bulk_out_ctrl.sv
// Bulk OUT endpoint transaction controller: admission by FIFO credit, DATA0/1 toggle, abort and handshake.
// Optional HS PING/NYET flow control is built when BULK_OUT_PING_EN is defined.
module bulk_out_ctrl #(
    parameter int unsigned MAX_PKT = 512,
    parameter int unsigned DEPTH   = 2048,
    parameter int unsigned CBITS   = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tok_out_i,
    input  logic                 tok_ping_i,
    input  logic                 rx_pid_d1_i,
    bulk_out_ctrl_if.slave       rx,
    input  logic                 rx_crc_ok_i,
    bulk_out_ctrl_if.master      fifo,
    output logic                 fifo_abort_o,
    input  logic                 fifo_drain_i,
    input  logic                 stall_i,
    input  logic                 toggle_clr_i,
    output logic                 hsk_valid_o,
    input  logic                 hsk_ready_i,
    output logic [1:0]           hsk_pid_o,
    output logic [CBITS-1:0]     credit_o
);

    typedef enum logic [2:0] {S_IDLE, S_ADMIT, S_RECV, S_SINK, S_HSK} state_t;
    typedef enum logic [1:0] {PID_ACK = 2'b00, PID_NAK = 2'b01, PID_NYET = 2'b10, PID_STALL = 2'b11} hsk_t;

    localparam logic [CBITS-1:0] DEPTH_C = CBITS'(DEPTH);
    localparam logic [CBITS-1:0] MAX_C   = CBITS'(MAX_PKT);

    state_t           state_q, state_d;
    hsk_t             hsk_pid_q, hsk_pid_d;
    logic [CBITS-1:0] credit_q, credit_d;
    logic [CBITS-1:0] pcnt_q, pcnt_d;
    logic             toggle_q, toggle_d;
    logic             babble_q, babble_d;
    logic             abort_q, abort_d;

    logic             drain_ok, dup_first, at_max, wr, flip, nyet;
    logic [CBITS:0]   credit_sum, credit_commit;

    assign drain_ok  = fifo_drain_i && (credit_q != DEPTH_C);
    assign dup_first = (pcnt_q == '0) && (rx_pid_d1_i != toggle_q);
    assign at_max    = (pcnt_q == MAX_C);
    // Credit as it will stand after a committing last byte (that byte's write included).
    assign credit_commit = {1'b0, credit_q} + {{CBITS{1'b0}}, drain_ok} - {{CBITS{1'b0}}, 1'b1};

`ifdef BULK_OUT_PING_EN
    assign nyet = credit_commit < {1'b0, MAX_C};
`else
    logic unused_ping;
    assign unused_ping = tok_ping_i;
    assign nyet        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        hsk_pid_d   = hsk_pid_q;
        pcnt_d      = pcnt_q;
        babble_d    = babble_q;
        abort_d     = 1'b0;
        flip        = 1'b0;
        wr          = 1'b0;
        rx.tready   = 1'b0;
        fifo.tvalid = 1'b0;
        fifo.tlast  = rx.tlast;
        fifo.tdata  = rx.tdata;

        case (state_q)
            S_IDLE: begin
                babble_d = 1'b0;
                if (tok_out_i) begin
                    state_d = S_ADMIT;
                end
`ifdef BULK_OUT_PING_EN
                else if (tok_ping_i) begin
                    state_d = S_HSK;
                    if (stall_i)                hsk_pid_d = PID_STALL;
                    else if (credit_q >= MAX_C) hsk_pid_d = PID_ACK;
                    else                        hsk_pid_d = PID_NAK;
                end
`endif
            end
            S_ADMIT: begin
                pcnt_d   = '0;
                babble_d = 1'b0;
                if (stall_i) begin
                    state_d   = S_SINK;
                    hsk_pid_d = PID_STALL;
                end else if (credit_q < MAX_C) begin
                    state_d   = S_SINK;
                    hsk_pid_d = PID_NAK;
                end else begin
                    state_d   = S_RECV;
                    hsk_pid_d = PID_ACK;
                end
            end
            S_RECV: begin
                // Duplicate first byte and babble bytes are swallowed here, never reaching the FIFO.
                if (dup_first || at_max) begin
                    rx.tready = 1'b1;
                    if (rx.tvalid) begin
                        babble_d = at_max;
                        if (!rx.tlast) begin
                            state_d = S_SINK;
                        end else if (at_max) begin
                            abort_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = rx_crc_ok_i ? S_HSK : S_IDLE;
                        end
                    end
                end else begin
                    fifo.tvalid = rx.tvalid;
                    rx.tready   = fifo.tready;
                    if (rx.tvalid && fifo.tready) begin
                        wr     = 1'b1;
                        pcnt_d = pcnt_q + CBITS'(1);
                        if (rx.tlast) begin
                            if (rx_crc_ok_i) begin
                                flip      = 1'b1;
                                state_d   = S_HSK;
                                hsk_pid_d = nyet ? PID_NYET : PID_ACK;
                            end else begin
                                abort_d = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
            end
            S_SINK: begin
                rx.tready = 1'b1;
                if (rx.tvalid && rx.tlast) begin
                    if (babble_q) begin
                        abort_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = rx_crc_ok_i ? S_HSK : S_IDLE;
                    end
                end
            end
            S_HSK: begin
                if (hsk_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        credit_sum = {1'b0, credit_q} + {{CBITS{1'b0}}, drain_ok} - {{CBITS{1'b0}}, wr}
                   + (abort_q ? {1'b0, pcnt_q} : '0);
        credit_d   = (credit_sum > {1'b0, DEPTH_C}) ? DEPTH_C : credit_sum[CBITS-1:0];
        toggle_d   = toggle_clr_i ? 1'b0 : (flip ? ~toggle_q : toggle_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hsk_pid_q <= PID_ACK;
            credit_q  <= DEPTH_C;
            pcnt_q    <= '0;
            toggle_q  <= 1'b0;
            babble_q  <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hsk_pid_q <= hsk_pid_d;
            credit_q  <= credit_d;
            pcnt_q    <= pcnt_d;
            toggle_q  <= toggle_d;
            babble_q  <= babble_d;
            abort_q   <= abort_d;
        end
    end

    assign hsk_valid_o  = (state_q == S_HSK);
    assign hsk_pid_o    = hsk_pid_q;
    assign fifo_abort_o = abort_q;
    assign credit_o     = credit_q;

endmodule

// File: tb/tb_bulk_out_ctrl.sv
// Directed bench for bulk_out_ctrl: a table of OUT/PING/drain transactions with hand-computed results.
module tb_bulk_out_ctrl;

    localparam int CBITS = 12;
`ifdef BULK_OUT_PING_EN
    localparam bit PG = 1'b1;
`else
    localparam bit PG = 1'b0;
`endif

    localparam int K_OUT = 0, K_PING = 1, K_DRAIN = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tok_out_i = 1'b0, tok_ping_i = 1'b0, rx_pid_d1_i = 1'b0, rx_crc_ok_i = 1'b1;
    logic fifo_abort_o, fifo_drain_i = 1'b0, stall_i = 1'b0, toggle_clr_i = 1'b0;
    logic hsk_valid_o, hsk_ready_i = 1'b0;
    logic [1:0] hsk_pid_o;
    logic [CBITS-1:0] credit_o;
    bit bp_en = 1'b0;

    bulk_out_ctrl_if rx_if();
    bulk_out_ctrl_if fifo_if();

    bulk_out_ctrl #(.MAX_PKT(512), .DEPTH(2048), .CBITS(CBITS)) dut (
        .clock(clock), .reset(reset), .tok_out_i(tok_out_i), .tok_ping_i(tok_ping_i),
        .rx_pid_d1_i(rx_pid_d1_i), .rx(rx_if), .rx_crc_ok_i(rx_crc_ok_i), .fifo(fifo_if),
        .fifo_abort_o(fifo_abort_o), .fifo_drain_i(fifo_drain_i), .stall_i(stall_i),
        .toggle_clr_i(toggle_clr_i), .hsk_valid_o(hsk_valid_o), .hsk_ready_i(hsk_ready_i),
        .hsk_pid_o(hsk_pid_o), .credit_o(credit_o)
    );

    always #5 clock = ~clock;

    always @(negedge clock) fifo_if.tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;

    int wr_cnt, abort_cnt, data_err, tlast_at;
    always @(posedge clock) begin
        if (fifo_if.tvalid && (fifo_if.tdata != rx_if.tdata || fifo_if.tlast != rx_if.tlast))
            data_err++;
        if (fifo_if.tvalid && fifo_if.tready) begin
            wr_cnt++;
            if (fifo_if.tlast) tlast_at = wr_cnt;
        end
        if (fifo_abort_o) abort_cnt++;
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int       kind;
        bit       pid;
        int       nbytes;
        bit       crc;
        bit       stall;
        bit       clr;
        bit       bp;
        bit       tokmid;
        bit       drw;
        int       expw;
        bit       exphsk;
        bit [1:0] exppid;
        int       expabort;
        int       expcredit;
    } vec_t;

    vec_t vecs[18];

    task automatic send_byte(input logic last, input logic dr, output bit ok);
        int g;
        rx_if.tvalid = 1'b1;
        rx_if.tdata  = 8'($urandom);
        rx_if.tlast  = last;
        g = 0;
        #1;
        while (!rx_if.tready && g < 64) begin
            @(negedge clock);
            #1;
            g++;
        end
        ok = rx_if.tready;
        fifo_drain_i = dr;
        @(negedge clock);
        rx_if.tvalid = 1'b0;
        rx_if.tlast  = 1'b0;
        fifo_drain_i = 1'b0;
    endtask

    task automatic check_hsk(input vec_t v);
        bit seen;
        if (v.exphsk) begin
            chk("hsk_rise", int'(hsk_valid_o), 1);
            chk("hsk_pid", int'(hsk_pid_o), int'(v.exppid));
            repeat (2) @(negedge clock);
            chk("hsk_hold", int'(hsk_valid_o), 1);
            hsk_ready_i = 1'b1;
            @(negedge clock);
            hsk_ready_i = 1'b0;
            chk("hsk_drop", int'(hsk_valid_o), 0);
        end else begin
            seen = 1'b0;
            repeat (6) begin
                if (hsk_valid_o) seen = 1'b1;
                @(negedge clock);
            end
            chk("no_hsk", int'(seen), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        //          kind    pid n    crc stl clr bp tm drw expw hsk pid                  abort credit
        vecs[0]  = '{K_OUT,   0, 512, 1, 0, 0, 1, 0, 0, 512, 1, 2'b00,                0, 1536};
        vecs[1]  = '{K_OUT,   0, 512, 1, 0, 0, 0, 0, 0,   0, 1, 2'b00,                0, 1536};
        vecs[2]  = '{K_OUT,   1, 512, 1, 0, 0, 0, 0, 0, 512, 1, 2'b00,                0, 1024};
        vecs[3]  = '{K_OUT,   0, 512, 1, 0, 0, 0, 0, 0, 512, 1, 2'b00,                0,  512};
        vecs[4]  = '{K_PING,  0,   0, 1, 0, 0, 0, 0, 0,   0, PG, 2'b00,               0,  512};
        vecs[5]  = '{K_OUT,   1, 212, 1, 0, 0, 0, 0, 0, 212, 1, PG ? 2'b10 : 2'b00,   0,  300};
        vecs[6]  = '{K_PING,  0,   0, 1, 0, 0, 0, 0, 0,   0, PG, 2'b01,               0,  300};
        vecs[7]  = '{K_OUT,   0,  64, 1, 0, 0, 0, 0, 0,   0, 1, 2'b01,                0,  300};
        vecs[8]  = '{K_DRAIN, 0, 300, 1, 0, 0, 0, 0, 0,   0, 0, 2'b00,                0,  600};
        vecs[9]  = '{K_OUT,   0, 100, 0, 0, 0, 0, 0, 0, 100, 0, 2'b00,                1,  600};
        vecs[10] = '{K_OUT,   1,   8, 1, 0, 0, 0, 0, 0,   0, 1, 2'b00,                0,  600};
        vecs[11] = '{K_OUT,   0,   8, 1, 0, 0, 0, 1, 1,   8, 1, 2'b00,                0,  600};
        vecs[12] = '{K_OUT,   1,   8, 1, 1, 0, 0, 0, 0,   0, 1, 2'b11,                0,  600};
        vecs[13] = '{K_OUT,   1, 520, 1, 0, 0, 0, 0, 0, 512, 0, 2'b00,                1,  600};
        vecs[14] = '{K_OUT,   0,   8, 1, 0, 1, 0, 0, 0,   8, 1, 2'b00,                0,  592};
        vecs[15] = '{K_DRAIN, 0,1500, 1, 0, 0, 0, 0, 0,   0, 0, 2'b00,                0, 2048};
        vecs[16] = '{K_OUT,   0,   8, 0, 0, 0, 0, 0, 0,   0, 0, 2'b00,                0, 2048};
        vecs[17] = '{K_PING,  0,   0, 1, 1, 0, 0, 0, 0,   0, PG, 2'b11,               0, 2048};

        rx_if.tvalid = 1'b0;
        rx_if.tlast  = 1'b0;
        rx_if.tdata  = '0;
        repeat (3) @(negedge clock);
        chk("rst_credit", int'(credit_o), 2048);
        chk("rst_hsk_valid", int'(hsk_valid_o), 0);
        chk("rst_hsk_pid", int'(hsk_pid_o), 0);
        chk("rst_rx_tready", int'(rx_if.tready), 0);
        chk("rst_fifo_tvalid", int'(fifo_if.tvalid), 0);
        chk("rst_abort", int'(fifo_abort_o), 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 18; i++) begin
            vec_t v;
            v = vecs[i];
            wr_cnt = 0; abort_cnt = 0; data_err = 0; tlast_at = -1;
            if (v.kind == K_DRAIN) begin
                fifo_drain_i = 1'b1;
                repeat (v.nbytes) @(negedge clock);
                fifo_drain_i = 1'b0;
                @(negedge clock);
                chk($sformatf("v%0d_credit", i), int'(credit_o), v.expcredit);
                continue;
            end
            if (v.clr) begin
                toggle_clr_i = 1'b1;
                @(negedge clock);
                toggle_clr_i = 1'b0;
            end
            stall_i = v.stall;
            bp_en   = v.bp;
            if (v.kind == K_PING) begin
                tok_ping_i = 1'b1;
                @(negedge clock);
                tok_ping_i = 1'b0;
            end else begin
                rx_pid_d1_i = v.pid;
                rx_crc_ok_i = v.crc;
                tok_out_i   = 1'b1;
                @(negedge clock);
                tok_out_i   = 1'b0;
                for (int b = 0; b < v.nbytes; b++) begin
                    tok_out_i = v.tokmid && (b == 3);
                    send_byte(b == v.nbytes - 1, v.drw, ok);
                    tok_out_i = 1'b0;
                    if (!ok) begin
                        chk($sformatf("v%0d_tready_timeout", i), 0, 1);
                        break;
                    end
                end
                bp_en = 1'b0;
            end
            check_hsk(v);
            stall_i = 1'b0;
            repeat (3) @(negedge clock);
            chk($sformatf("v%0d_writes", i), wr_cnt, v.expw);
            chk($sformatf("v%0d_aborts", i), abort_cnt, v.expabort);
            chk($sformatf("v%0d_credit", i), int'(credit_o), v.expcredit);
            chk($sformatf("v%0d_data", i), data_err, 0);
            if (v.expw > 0 && v.expabort == 0)
                chk($sformatf("v%0d_tlast_pos", i), tlast_at, v.expw);
        end

        // Abort pulse timing: exactly one cycle after a bad-CRC last byte, credit restored the cycle after.
        abort_cnt = 0;
        rx_pid_d1_i = 1'b1;
        rx_crc_ok_i = 1'b0;
        tok_out_i = 1'b1;
        @(negedge clock);
        tok_out_i = 1'b0;
        for (int b = 0; b < 4; b++) send_byte(b == 3, 1'b0, ok);
        chk("abort_pulse_now", int'(fifo_abort_o), 1);
        chk("credit_during_abort", int'(credit_o), 2044);
        @(negedge clock);
        chk("abort_pulse_gone", int'(fifo_abort_o), 0);
        chk("credit_after_abort", int'(credit_o), 2048);
        rx_crc_ok_i = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
